// File: rtl/seed_session_ctrl.sv
// Session sequencer for the SEED path: key, then N blocks through deserializer -> core -> serializer.
// Control-only; tracks order, block count, core stalls and overruns.
module seed_session_ctrl #(
  parameter int MAX_BLOCKS = 16,
  parameter int TIMEOUT    = 64,
  localparam int CW        = $clog2(MAX_BLOCKS + 1)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          cmd_start,
  input  logic          cmd_enc_dec,
  input  logic [CW-1:0] num_blocks,
  input  logic          key_valid,
  input  logic          blk_valid,
  output logic          in_ready,
  output logic          core_start,
  output logic          core_enc_dec,
  input  logic          core_done,
  output logic          ser_start,
  input  logic          ser_done,
  output logic          busy,
  output logic [CW-1:0] blk_cnt,
  output logic          done,
  output logic          error,
  output logic [1:0]    err_code
);

  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  localparam logic [1:0] ERR_NONE    = 2'b00;
  localparam logic [1:0] ERR_COUNT   = 2'b01;
  localparam logic [1:0] ERR_TIMEOUT = 2'b10;
  localparam logic [1:0] ERR_OVERRUN = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT_KEY,
    ST_WAIT_BLK,
    ST_CORE,
    ST_SEND,
    ST_ERR
  } state_t;

  state_t        state_q, state_d;
  logic          mode_q, mode_d;
  logic [CW-1:0] num_q, num_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [TW-1:0] tmr_q, tmr_d;
  logic [1:0]    err_code_q, err_code_d;
  logic          core_start_q, core_start_d;
  logic          ser_start_q, ser_start_d;
  logic          done_q, done_d;
  logic          busy_q, busy_d;
  logic          in_ready_q, in_ready_d;
  logic          error_q, error_d;

  logic          overrun;
  logic [CW-1:0] cnt_inc;

  assign overrun = key_valid | blk_valid;
  assign cnt_inc = cnt_q + CW'(1);

  always_comb begin
    state_d      = state_q;
    mode_d       = mode_q;
    num_d        = num_q;
    cnt_d        = cnt_q;
    tmr_d        = tmr_q;
    err_code_d   = err_code_q;
    core_start_d = 1'b0;
    ser_start_d  = 1'b0;
    done_d       = 1'b0;

    case (state_q)
      ST_IDLE, ST_ERR: begin
        if (cmd_start) begin
          mode_d     = cmd_enc_dec;
          num_d      = num_blocks;
          cnt_d      = '0;
          err_code_d = ERR_NONE;
          if (num_blocks == '0 || num_blocks > CW'(MAX_BLOCKS)) begin
            state_d    = ST_ERR;
            err_code_d = ERR_COUNT;
          end else begin
            state_d = ST_WAIT_KEY;
          end
        end
      end
      ST_WAIT_KEY: begin
        if (key_valid) state_d = ST_WAIT_BLK;
      end
      ST_WAIT_BLK: begin
        if (blk_valid) begin
          state_d      = ST_CORE;
          core_start_d = 1'b1;
          tmr_d        = '0;
        end
      end
      ST_CORE: begin
        // Overrun beats core_done, which in turn beats the timeout on the expiry cycle.
        if (overrun) begin
          state_d    = ST_ERR;
          err_code_d = ERR_OVERRUN;
        end else if (core_done) begin
          state_d     = ST_SEND;
          ser_start_d = 1'b1;
        end else if (tmr_q == TW'(TIMEOUT - 1)) begin
          state_d    = ST_ERR;
          err_code_d = ERR_TIMEOUT;
        end else begin
          tmr_d = tmr_q + TW'(1);
        end
      end
      ST_SEND: begin
        if (overrun) begin
          state_d    = ST_ERR;
          err_code_d = ERR_OVERRUN;
        end else if (ser_done) begin
          cnt_d = cnt_inc;
          if (cnt_inc == num_q) begin
            state_d = ST_IDLE;
            done_d  = 1'b1;
          end else begin
            state_d = ST_WAIT_BLK;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    busy_d     = (state_d == ST_WAIT_KEY) || (state_d == ST_WAIT_BLK) ||
                 (state_d == ST_CORE) || (state_d == ST_SEND);
    in_ready_d = (state_d == ST_WAIT_KEY) || (state_d == ST_WAIT_BLK);
    error_d    = (state_d == ST_ERR);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= ST_IDLE;
      mode_q       <= 1'b0;
      num_q        <= '0;
      cnt_q        <= '0;
      tmr_q        <= '0;
      err_code_q   <= ERR_NONE;
      core_start_q <= 1'b0;
      ser_start_q  <= 1'b0;
      done_q       <= 1'b0;
      busy_q       <= 1'b0;
      in_ready_q   <= 1'b0;
      error_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      mode_q       <= mode_d;
      num_q        <= num_d;
      cnt_q        <= cnt_d;
      tmr_q        <= tmr_d;
      err_code_q   <= err_code_d;
      core_start_q <= core_start_d;
      ser_start_q  <= ser_start_d;
      done_q       <= done_d;
      busy_q       <= busy_d;
      in_ready_q   <= in_ready_d;
      error_q      <= error_d;
    end
  end

  assign in_ready     = in_ready_q;
  assign core_start   = core_start_q;
  assign core_enc_dec = mode_q;
  assign ser_start    = ser_start_q;
  assign busy         = busy_q;
  assign blk_cnt      = cnt_q;
  assign done         = done_q;
  assign error        = error_q;
  assign err_code     = err_code_q;

endmodule

// File: tb/tb_seed_session_ctrl.sv
// Scenario bench for seed_session_ctrl: randomized sessions checked against expected pulse
// counts, block-count progression and fault timing derived from the session rules.
module tb_seed_session_ctrl;
  localparam int MAXB = 16;
  localparam int TMO  = 64;
  localparam int CW   = $clog2(MAXB + 1);

  logic          clk = 1'b0;
  logic          reset;
  logic          cmd_start, cmd_enc_dec;
  logic [CW-1:0] num_blocks;
  logic          key_valid, blk_valid, core_done, ser_done;
  logic          in_ready, core_start, core_enc_dec, ser_start, busy, done, error;
  logic [CW-1:0] blk_cnt;
  logic [1:0]    err_code;

  int checks = 0;
  int errors = 0;
  int n_core_start = 0;
  int n_ser_start = 0;
  int n_done = 0;

  seed_session_ctrl #(.MAX_BLOCKS(MAXB), .TIMEOUT(TMO)) dut (
    .clk(clk), .reset(reset), .cmd_start(cmd_start), .cmd_enc_dec(cmd_enc_dec),
    .num_blocks(num_blocks), .key_valid(key_valid), .blk_valid(blk_valid),
    .in_ready(in_ready), .core_start(core_start), .core_enc_dec(core_enc_dec),
    .core_done(core_done), .ser_start(ser_start), .ser_done(ser_done), .busy(busy),
    .blk_cnt(blk_cnt), .done(done), .error(error), .err_code(err_code)
  );

  always #5 clk = ~clk;

  // Pulse tally, sampled mid-cycle.
  always @(negedge clk) begin
    if (core_start === 1'b1) n_core_start++;
    if (ser_start === 1'b1) n_ser_start++;
    if (done === 1'b1) n_done++;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    cmd_start = 0; cmd_enc_dec = 0; num_blocks = '0;
    key_valid = 0; blk_valid = 0; core_done = 0; ser_done = 0;
  endtask

  // Full session; core_lat < 0 picks a random core latency per block.
  task automatic run_session(input logic mode, input int n, input bit noise, input int core_lat);
    int cs0, ss0, dn0, gap, lat;
    cs0 = n_core_start; ss0 = n_ser_start; dn0 = n_done;
    cmd_enc_dec = mode; num_blocks = CW'(n); cmd_start = 1; step();
    cmd_start = 0; cmd_enc_dec = ~mode; num_blocks = CW'($urandom);
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL start_busy: got %b want 1", busy); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL start_in_ready: got %b want 1", in_ready); end
    checks++; if (error !== 1'b0 || err_code !== 2'b00) begin errors++; $display("FAIL start_err_clear: got error=%b code=%b want 0/00", error, err_code); end
    checks++; if (blk_cnt !== '0) begin errors++; $display("FAIL start_blk_cnt: got %0d want 0", blk_cnt); end
    gap = $urandom_range(0, 3);
    repeat (gap) begin
      if (noise) blk_valid = 1'($urandom_range(0, 1));
      step(); blk_valid = 0;
    end
    key_valid = 1; step(); key_valid = 0;
    checks++; if (in_ready !== 1'b1 || busy !== 1'b1) begin errors++; $display("FAIL key_accept: got in_ready=%b busy=%b want 1/1", in_ready, busy); end
    for (int b = 0; b < n; b++) begin
      gap = $urandom_range(0, 3);
      repeat (gap) begin
        if (noise) begin
          key_valid = 1'($urandom_range(0, 1)); core_done = 1'($urandom_range(0, 1));
          ser_done = 1'($urandom_range(0, 1)); cmd_start = 1'($urandom_range(0, 1));
          cmd_enc_dec = 1'($urandom_range(0, 1)); num_blocks = CW'($urandom);
        end
        step();
        key_valid = 0; core_done = 0; ser_done = 0; cmd_start = 0;
      end
      checks++; if (in_ready !== 1'b1 || core_start !== 1'b0) begin errors++; $display("FAIL wait_blk_idle: got in_ready=%b core_start=%b want 1/0", in_ready, core_start); end
      blk_valid = 1; step(); blk_valid = 0;
      checks++; if (core_start !== 1'b1 || in_ready !== 1'b0) begin errors++; $display("FAIL blk%0d_core_start: got core_start=%b in_ready=%b want 1/0", b, core_start, in_ready); end
      checks++; if (core_enc_dec !== mode) begin errors++; $display("FAIL blk%0d_mode: got %b want %b", b, core_enc_dec, mode); end
      lat = (core_lat < 0) ? $urandom_range(0, 12) : core_lat;
      repeat (lat) step();
      checks++; if (ser_start !== 1'b0 || busy !== 1'b1) begin errors++; $display("FAIL blk%0d_core_wait: got ser_start=%b busy=%b want 0/1", b, ser_start, busy); end
      core_done = 1; step(); core_done = 0;
      checks++; if (ser_start !== 1'b1 || core_start !== 1'b0) begin errors++; $display("FAIL blk%0d_ser_start: got ser_start=%b core_start=%b want 1/0", b, ser_start, core_start); end
      lat = $urandom_range(0, 12);
      repeat (lat) step();
      checks++; if (blk_cnt !== CW'(b)) begin errors++; $display("FAIL blk%0d_cnt_hold: got %0d want %0d", b, blk_cnt, b); end
      ser_done = 1; step(); ser_done = 0;
      checks++; if (blk_cnt !== CW'(b + 1)) begin errors++; $display("FAIL blk%0d_cnt_step: got %0d want %0d", b, blk_cnt, b + 1); end
      if (b == n - 1) begin
        checks++; if (done !== 1'b1 || busy !== 1'b0 || in_ready !== 1'b0) begin errors++; $display("FAIL last_done: got done=%b busy=%b in_ready=%b want 1/0/0", done, busy, in_ready); end
      end else begin
        checks++; if (done !== 1'b0 || in_ready !== 1'b1) begin errors++; $display("FAIL blk%0d_next: got done=%b in_ready=%b want 0/1", b, done, in_ready); end
      end
    end
    step();
    checks++; if (done !== 1'b0 || error !== 1'b0 || blk_cnt !== CW'(n)) begin errors++; $display("FAIL session_end: got done=%b error=%b blk_cnt=%0d want 0/0/%0d", done, error, blk_cnt, n); end
    checks++; if (n_core_start - cs0 != n || n_ser_start - ss0 != n || n_done - dn0 != 1) begin
      errors++; $display("FAIL pulse_counts: got core_start=%0d ser_start=%0d done=%0d want %0d/%0d/1", n_core_start - cs0, n_ser_start - ss0, n_done - dn0, n, n);
    end
  endtask

  // Opens a session and delivers key plus first block; returns in the first CORE cycle.
  task automatic open_to_core(input logic mode, input int n);
    cmd_enc_dec = mode; num_blocks = CW'(n); cmd_start = 1; step(); cmd_start = 0;
    key_valid = 1; step(); key_valid = 0;
    blk_valid = 1; step(); blk_valid = 0;
  endtask

  task automatic test_reset();
    clear_inputs();
    reset = 0;
    repeat (3) step();
    checks++; if ({busy, in_ready, core_start, ser_start, done, error, core_enc_dec} !== 7'b0 || blk_cnt !== '0 || err_code !== 2'b00) begin
      errors++; $display("FAIL reset_outputs: got busy=%b in_ready=%b error=%b blk_cnt=%0d code=%b want all 0", busy, in_ready, error, blk_cnt, err_code);
    end
    reset = 1; step(); step();
    checks++; if (busy !== 1'b0 || in_ready !== 1'b0 || error !== 1'b0) begin errors++; $display("FAIL idle_after_reset: got busy=%b in_ready=%b error=%b want 0/0/0", busy, in_ready, error); end
  endtask

  task automatic test_encrypt3();
    run_session(1'b1, 3, 1'b0, 10);
  endtask

  task automatic test_bad_count();
    int bad [3];
    bad[0] = 0; bad[1] = MAXB + 1; bad[2] = $urandom_range(MAXB + 1, (1 << CW) - 1);
    for (int i = 0; i < 3; i++) begin
      cmd_enc_dec = 1'b1; num_blocks = CW'(bad[i]); cmd_start = 1; step(); cmd_start = 0;
      checks++; if (error !== 1'b1 || err_code !== 2'b01 || busy !== 1'b0 || in_ready !== 1'b0) begin
        errors++; $display("FAIL bad_count_%0d: got error=%b code=%b busy=%b in_ready=%b want 1/01/0/0", bad[i], error, err_code, busy, in_ready);
      end
      key_valid = 1; blk_valid = 1; step(); key_valid = 0; blk_valid = 0; step();
      checks++; if (error !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL err_sticky_%0d: got error=%b busy=%b want 1/0", bad[i], error, busy); end
    end
    run_session(1'b0, 1, 1'b0, -1);
  endtask

  task automatic test_timeout();
    open_to_core(1'b1, 2);
    repeat (TMO - 1) step();
    checks++; if (error !== 1'b0 || busy !== 1'b1) begin errors++; $display("FAIL timeout_early: got error=%b busy=%b want 0/1", error, busy); end
    step();
    checks++; if (error !== 1'b1 || err_code !== 2'b10 || busy !== 1'b0 || in_ready !== 1'b0) begin
      errors++; $display("FAIL timeout_err: got error=%b code=%b busy=%b in_ready=%b want 1/10/0/0", error, err_code, busy, in_ready);
    end
    open_to_core(1'b0, 1);
    checks++; if (error !== 1'b0 || err_code !== 2'b00) begin errors++; $display("FAIL err_cleared: got error=%b code=%b want 0/00", error, err_code); end
    repeat (TMO - 1) step();
    core_done = 1; step(); core_done = 0;
    checks++; if (ser_start !== 1'b1 || error !== 1'b0 || busy !== 1'b1) begin
      errors++; $display("FAIL expiry_done_wins: got ser_start=%b error=%b busy=%b want 1/0/1", ser_start, error, busy);
    end
    ser_done = 1; step(); ser_done = 0;
    checks++; if (done !== 1'b1 || blk_cnt !== CW'(1)) begin errors++; $display("FAIL expiry_finish: got done=%b blk_cnt=%0d want 1/1", done, blk_cnt); end
  endtask

  task automatic test_overrun();
    open_to_core(1'b1, 2);
    repeat ($urandom_range(0, 10)) step();
    blk_valid = 1; core_done = 1; step(); blk_valid = 0; core_done = 0;
    checks++; if (error !== 1'b1 || err_code !== 2'b11 || ser_start !== 1'b0 || busy !== 1'b0) begin
      errors++; $display("FAIL overrun_core: got error=%b code=%b ser_start=%b busy=%b want 1/11/0/0", error, err_code, ser_start, busy);
    end
    open_to_core(1'b0, 1);
    core_done = 1; step(); core_done = 0;
    key_valid = 1; ser_done = 1; step(); key_valid = 0; ser_done = 0;
    checks++; if (error !== 1'b1 || err_code !== 2'b11 || done !== 1'b0 || blk_cnt !== '0) begin
      errors++; $display("FAIL overrun_send: got error=%b code=%b done=%b blk_cnt=%0d want 1/11/0/0", error, err_code, done, blk_cnt);
    end
  endtask

  task automatic test_reset_mid();
    open_to_core(1'b1, 4);
    core_done = 1; step(); core_done = 0;
    ser_done = 1; step(); ser_done = 0;
    blk_valid = 1; step(); blk_valid = 0;
    core_done = 1; step(); core_done = 0;
    checks++; if (ser_start !== 1'b1 || blk_cnt !== CW'(1) || core_enc_dec !== 1'b1) begin
      errors++; $display("FAIL pre_reset_send: got ser_start=%b blk_cnt=%0d mode=%b want 1/1/1", ser_start, blk_cnt, core_enc_dec);
    end
    reset = 0; #1;
    checks++; if ({busy, in_ready, core_start, ser_start, done, error, core_enc_dec} !== 7'b0 || blk_cnt !== '0 || err_code !== 2'b00) begin
      errors++; $display("FAIL async_reset: got busy=%b ser_start=%b mode=%b blk_cnt=%0d code=%b want all 0", busy, ser_start, core_enc_dec, blk_cnt, err_code);
    end
    step(); reset = 1; step();
    run_session(1'b0, 1, 1'b0, -1);
  endtask

  task automatic test_noise_and_random();
    run_session(1'b1, 3, 1'b1, -1);
    for (int i = 0; i < 6; i++) begin
      run_session(1'($urandom_range(0, 1)), $urandom_range(1, 5), 1'($urandom_range(0, 1)), -1);
    end
    run_session(1'b0, MAXB, 1'b0, 0);
  endtask

  initial begin
    test_reset();
    test_encrypt3();
    test_bad_count();
    test_timeout();
    test_overrun();
    test_reset_mid();
    test_noise_and_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/seed_session_ctrl.md
# seed_session_ctrl

Session controller for the SEED encryption path. It sequences one key followed by N 128-bit blocks through three stages: the byte deserializer, the SEED core and the byte serializer toward the Raspberry Pi. It enforces the order key → block → core → serializer for every block, counts blocks, and detects stalled-core and overrun faults. It is control-only: it carries no key or data bits, only start/done handshakes, mode, and status.

## Interface
Parameters:
- MAX_BLOCKS, 16: largest legal session length; counter width CW = clog2(MAX_BLOCKS+1).
- TIMEOUT, 64: cycles allowed between core_start and core_done.

Ports (one clock; reset is asynchronous and active-low):
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low; clears all state.
- cmd_start  in  1  host pulse that opens a session.
- cmd_enc_dec  in  1  mode, sampled at cmd_start (1 = encrypt, 0 = decrypt).
- num_blocks  in  CW  block count, sampled at cmd_start.
- key_valid  in  1  deserializer pulse: 128-bit key assembled.
- blk_valid  in  1  deserializer pulse: 128-bit data block assembled.
- in_ready  out  1  deserializer may deliver the next key or block.
- core_start  out  1  one-cycle start pulse to the SEED core.
- core_enc_dec  out  1  mode held for the whole session.
- core_done  in  1  SEED core result valid (out_en).
- ser_start  out  1  one-cycle pulse telling the serializer to ship the result.
- ser_done  in  1  serializer has sent all 16 bytes.
- busy  out  1  high in every state except IDLE and ERR.
- blk_cnt  out  CW  number of blocks fully sent in this session.
- done  out  1  one-cycle pulse when the session completes.
- error  out  1  sticky fault flag.
- err_code  out  2  fault cause: 01 bad count, 10 core timeout, 11 overrun; 00 when no fault.

## Operation
- States: IDLE, WAIT_KEY, WAIT_BLK, CORE, SEND, ERR. All outputs are registered.
- IDLE or ERR, cmd_start=1:
  - Latch mode and num_blocks, clear blk_cnt, error and err_code.
  - If num_blocks==0 or num_blocks>MAX_BLOCKS: go to ERR with code 01.
  - Otherwise go to WAIT_KEY.
- WAIT_KEY: in_ready=1. key_valid → WAIT_BLK.
- WAIT_BLK: in_ready=1. blk_valid → CORE, with a core_start pulse on the first CORE cycle.
- CORE:
  - Timeout counter is cleared on entry and increments every cycle.
  - core_done → SEND, with a ser_start pulse on the first SEND cycle.
  - Counter reaches TIMEOUT-1 without core_done → ERR, code 10.
  - If core_done and the timeout hit the same cycle, core_done wins.
- SEND: ser_done → blk_cnt+1.
  - If the new count equals num_blocks: go to IDLE and pulse done.
  - Otherwise go to WAIT_BLK.
- Overrun: key_valid or blk_valid while in CORE or SEND → ERR, code 11. This takes priority over core_done or ser_done arriving in the same cycle.
- Ignored inputs:
  - key_valid in WAIT_BLK.
  - blk_valid in WAIT_KEY.
  - cmd_start while busy.
  - core_done or ser_done in any state other than CORE and SEND respectively.
- ERR: busy=0, in_ready=0, error=1. Only cmd_start or reset leaves ERR.
- Mode change: core_enc_dec changes only at cmd_start.
- Reset (asserted at any time, including mid-session): state=IDLE and every output is 0, including blk_cnt, err_code and core_enc_dec. In-flight core or serializer activity is abandoned.

## Timing
- cmd_start at edge t → busy and in_ready high from t+1.
- blk_valid at edge t → core_start high during cycle t+1 only; in_ready low from t+1.
- core_done at edge t → ser_start high during cycle t+1 only.
- ser_done at edge t:
  - blk_cnt updates at t+1.
  - Last block: done=1 and busy=0 at t+1.
  - Otherwise in_ready=1 at t+1.
- Timeout: core_start in cycle s with no core_done → ERR visible at s+TIMEOUT.
- Minimum per-block turnaround beyond core and serializer latency: 3 cycles of control overhead.

## Test plan
- Encrypt, num_blocks=3: three blocks with a core that answers after 10 cycles → three core_start and three ser_start pulses, blk_cnt steps 1,2,3, one done pulse, core_enc_dec=1 throughout, error=0.
- num_blocks=0, then num_blocks=17 → ERR with err_code=01, busy=0. A following valid cmd_start (num_blocks=1) clears error and runs to done.
- Core never responds: after core_start, ERR appears exactly 64 cycles later with code 10. Repeat with core_done landing on the expiry cycle → SEND is entered, no error.
- blk_valid pulsed during CORE → ERR code 11, even when core_done is high in the same cycle.
- Reset pulsed low during SEND of block 2 of 4 → outputs clear immediately. After release, a cmd_start with num_blocks=1 completes with blk_cnt=1.
- cmd_start re-pulsed mid-session and stray core_done in WAIT_BLK → both ignored, and the session still finishes with correct counts.
